// File: rtl/latency_pkg.sv
// rtl/latency_pkg.sv - shared defaults and counter-width helper for latency_return_buffer
package latency_pkg;

  localparam int DEFAULT_WIDTH   = 8;
  localparam int DEFAULT_LATENCY = 4;
  localparam int DEFAULT_DEPTH   = 8;

  // Width able to hold every value 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ring_buffer.sv
// rtl/ring_buffer.sv - circular result store with push/pop/full/empty; contents are not reset
module ring_buffer
  import latency_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  assign o_pop_data = r_mem[r_rd_ptr];
  assign o_full     = (r_count == CW'(DEPTH));
  assign o_empty    = (r_count == '0);

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/latency_return_buffer.sv
// rtl/latency_return_buffer.sv - credit-gated return buffer for a fixed-latency pipe; LATENCY_RETURN_BUFFER_CHECK_EN adds the return checker
module latency_return_buffer
  import latency_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int LATENCY = DEFAULT_LATENCY,
  parameter int DEPTH   = DEFAULT_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  output logic                        issue_ready,
  input  logic                        issue_valid,
  input  logic                        ret_valid,
  input  logic [WIDTH-1:0]            ret_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [cnt_width(DEPTH)-1:0] credits_used,
  output logic                        err
);

  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);

  logic          w_issue_fire;
  logic          w_out_fire;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic [CW-1:0] r_credits;

  assign issue_ready  = (r_credits < LP_DEPTH);
  assign w_issue_fire = issue_valid & issue_ready;
  assign out_valid    = ~w_empty;
  assign w_out_fire   = out_valid & out_ready;
  assign credits_used = r_credits;

  // A return into a full buffer is only accepted when the head leaves in the same cycle.
  assign w_push = ret_valid & (~w_full | w_out_fire);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_credits <= '0;
    end else begin
      case ({w_issue_fire, w_out_fire})
        2'b10:   r_credits <= r_credits + 1'b1;
        2'b01:   r_credits <= r_credits - 1'b1;
        default: r_credits <= r_credits;
      endcase
    end
  end

  ring_buffer #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_ring (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_push),
    .i_push_data(ret_data),
    .i_pop      (w_out_fire),
    .o_pop_data (out_data),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

`ifdef LATENCY_RETURN_BUFFER_CHECK_EN
  logic w_shadow_out;
  logic r_err;

  if (LATENCY == 0) begin : g_no_shadow
    assign w_shadow_out = w_issue_fire;
  end else begin : g_shadow
    logic [LATENCY-1:0] r_shadow;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_shadow <= '0;
      end else begin
        r_shadow[0] <= w_issue_fire;
        for (int i = 1; i < LATENCY; i++) r_shadow[i] <= r_shadow[i-1];
      end
    end
    assign w_shadow_out = r_shadow[LATENCY-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else begin
      r_err <= r_err | (ret_valid != w_shadow_out) | (ret_valid & w_full & ~w_out_fire);
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_latency_return_buffer.sv
// tb/tb_latency_return_buffer.sv - directed self-checking bench with a 4-cycle pipe model
module tb_latency_return_buffer;

  localparam int WIDTH   = 8;
  localparam int LATENCY = 4;
  localparam int DEPTH   = 8;

  logic             clk;
  logic             reset;
  logic             issue_ready;
  logic             issue_valid;
  logic [WIDTH-1:0] issue_data;
  logic             ret_valid;
  logic [WIDTH-1:0] ret_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [3:0]       credits_used;
  logic             err;
  logic             inj;
  logic [WIDTH-1:0] inj_data;

  int n_pass;
  int n_total;

  logic             pv [LATENCY];
  logic [WIDTH-1:0] pd [LATENCY];

  latency_return_buffer #(
    .WIDTH(WIDTH),
    .LATENCY(LATENCY),
    .DEPTH(DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .issue_ready (issue_ready),
    .issue_valid (issue_valid),
    .ret_valid   (ret_valid),
    .ret_data    (ret_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .credits_used(credits_used),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pipe model: an accepted issue emerges as a return LATENCY edges later.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        pv[i] <= 1'b0;
        pd[i] <= '0;
      end
    end else begin
      pv[0] <= issue_valid & issue_ready;
      pd[0] <= issue_data;
      for (int i = 1; i < LATENCY; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  assign ret_valid = pv[LATENCY-1] | inj;
  assign ret_data  = inj ? inj_data : pd[LATENCY-1];

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_total++; if (issue_ready !== 1'b1) $display("FAIL reset_issue_ready: got %b want 1", issue_ready); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (credits_used !== 4'd0) $display("FAIL reset_credits: got %0d want 0", credits_used); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else n_pass++;
    reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    issue_valid = 1'b1;
    issue_data  = 8'h5A;
    step();
    issue_valid = 1'b0;
    n_total++; if (credits_used !== 4'd1) $display("FAIL single_credits_issue: got %0d want 1", credits_used); else n_pass++;
    step(); step(); step();
    n_total++; if (out_valid !== 1'b0) $display("FAIL single_early_valid: got %b want 0", out_valid); else n_pass++;
    step();
    n_total++; if (out_valid !== 1'b1) $display("FAIL single_out_valid: got %b want 1", out_valid); else n_pass++;
    n_total++; if (out_data !== 8'h5A) $display("FAIL single_out_data: got %h want 5a", out_data); else n_pass++;
    n_total++; if (credits_used !== 4'd1) $display("FAIL single_credits_held: got %0d want 1", credits_used); else n_pass++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_total++; if (credits_used !== 4'd0) $display("FAIL single_credits_release: got %0d want 0", credits_used); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL single_drained: got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_backpressure();
    int n_fire;
    n_fire = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      issue_valid = 1'b1;
      issue_data  = 8'h10 + 8'(n_fire);
      if (issue_ready) n_fire++;
      step();
    end
    issue_valid = 1'b0;
    n_total++; if (n_fire !== 8) $display("FAIL bp_fire_count: got %0d want 8", n_fire); else n_pass++;
    n_total++; if (credits_used !== 4'd8) $display("FAIL bp_credits_full: got %0d want 8", credits_used); else n_pass++;
    n_total++; if (issue_ready !== 1'b0) $display("FAIL bp_issue_ready_low: got %b want 0", issue_ready); else n_pass++;
    step(); step(); step();
    n_total++; if (out_data !== 8'h10) $display("FAIL bp_head: got %h want 10", out_data); else n_pass++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_total++; if (issue_ready !== 1'b1) $display("FAIL bp_credit_return: got %b want 1", issue_ready); else n_pass++;
    n_total++; if (credits_used !== 4'd7) $display("FAIL bp_credits_after_pop: got %0d want 7", credits_used); else n_pass++;
    for (int k = 1; k < 8; k++) begin
      n_total++;
      if (out_valid !== 1'b1 || out_data !== 8'h10 + 8'(k))
        $display("FAIL bp_drain_%0d: got valid=%b data=%h want valid=1 data=%h", k, out_valid, out_data, 8'h10 + 8'(k));
      else n_pass++;
      out_ready = 1'b1;
      step();
    end
    out_ready = 1'b0;
    n_total++; if (out_valid !== 1'b0) $display("FAIL bp_empty: got %b want 0", out_valid); else n_pass++;
    n_total++; if (credits_used !== 4'd0) $display("FAIL bp_credits_empty: got %0d want 0", credits_used); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] got [$];
    int first_cyc;
    int last_cyc;
    bit stalled;
    stalled   = 1'b0;
    first_cyc = -1;
    last_cyc  = -1;
    out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (out_valid) begin
        got.push_back(out_data);
        if (first_cyc < 0) first_cyc = c;
        last_cyc = c;
      end
      if (c < 20 && !issue_ready) stalled = 1'b1;
      issue_valid = (c < 20);
      issue_data  = 8'h40 + 8'(c);
      step();
    end
    issue_valid = 1'b0;
    out_ready   = 1'b0;
    n_total++; if (stalled !== 1'b0) $display("FAIL b2b_issue_stall: got %b want 0", stalled); else n_pass++;
    n_total++; if (got.size() !== 20) $display("FAIL b2b_count: got %0d want 20", got.size()); else n_pass++;
    n_total++; if (first_cyc !== 5) $display("FAIL b2b_first_latency: got %0d want 5", first_cyc); else n_pass++;
    n_total++; if (last_cyc - first_cyc !== 19) $display("FAIL b2b_gapless: got %0d want 19", last_cyc - first_cyc); else n_pass++;
    for (int i = 0; i < got.size() && i < 20; i++) begin
      n_total++;
      if (got[i] !== 8'h40 + 8'(i)) $display("FAIL b2b_order_%0d: got %h want %h", i, got[i], 8'h40 + 8'(i));
      else n_pass++;
    end
  endtask

  task automatic test_full_wrap();
    logic [WIDTH-1:0] exp_q [$];
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      issue_valid = 1'b1;
      issue_data  = 8'h80 + 8'(i);
      step();
    end
    issue_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    n_total++; if (out_valid !== 1'b1 || out_data !== 8'h80) $display("FAIL full_head: got valid=%b data=%h want valid=1 data=80", out_valid, out_data); else n_pass++;
    inj       = 1'b1;
    inj_data  = 8'h99;
    out_ready = 1'b1;
    step();
    inj = 1'b0;
    for (int i = 1; i < 8; i++) exp_q.push_back(8'h80 + 8'(i));
    exp_q.push_back(8'h99);
    for (int k = 0; k < 8; k++) begin
      n_total++;
      if (out_valid !== 1'b1 || out_data !== exp_q[k])
        $display("FAIL full_wrap_%0d: got valid=%b data=%h want valid=1 data=%h", k, out_valid, out_data, exp_q[k]);
      else n_pass++;
      step();
    end
    out_ready = 1'b0;
    n_total++; if (out_valid !== 1'b0) $display("FAIL full_wrap_empty: got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      issue_valid = 1'b1;
      issue_data  = 8'h60 + 8'(i);
      step();
    end
    issue_valid = 1'b0;
    step();
    n_total++; if (credits_used !== 4'd8) $display("FAIL mid_credits_before: got %0d want 8", credits_used); else n_pass++;
    reset = 1'b1;
    step();
    n_total++; if (issue_ready !== 1'b1) $display("FAIL mid_issue_ready: got %b want 1", issue_ready); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (credits_used !== 4'd0) $display("FAIL mid_credits: got %0d want 0", credits_used); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL mid_err: got %b want 0", err); else n_pass++;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) step();
    n_total++; if (out_valid !== 1'b0) $display("FAIL mid_inflight_discarded: got %b want 0", out_valid); else n_pass++;
    issue_valid = 1'b1;
    issue_data  = 8'hC3;
    step();
    issue_valid = 1'b0;
    step(); step(); step(); step();
    n_total++; if (out_valid !== 1'b1 || out_data !== 8'hC3) $display("FAIL mid_post_reset_data: got valid=%b data=%h want valid=1 data=c3", out_valid, out_data); else n_pass++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_total++; if (credits_used !== 4'd0) $display("FAIL mid_post_reset_credits: got %0d want 0", credits_used); else n_pass++;
  endtask

  task automatic test_err();
    n_total++; if (err !== 1'b0) $display("FAIL err_initial: got %b want 0", err); else n_pass++;
    inj       = 1'b1;
    inj_data  = 8'hEE;
    step();
    inj       = 1'b0;
    out_ready = 1'b1;
`ifdef LATENCY_RETURN_BUFFER_CHECK_EN
    n_total++; if (err !== 1'b1) $display("FAIL err_set: got %b want 1", err); else n_pass++;
    step(); step(); step();
    n_total++; if (err !== 1'b1) $display("FAIL err_sticky: got %b want 1", err); else n_pass++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_total++; if (err !== 1'b0) $display("FAIL err_cleared: got %b want 0", err); else n_pass++;
`else
    n_total++; if (err !== 1'b0) $display("FAIL err_tied_low: got %b want 0", err); else n_pass++;
    step(); step();
    n_total++; if (err !== 1'b0) $display("FAIL err_stays_low: got %b want 0", err); else n_pass++;
`endif
    out_ready = 1'b0;
  endtask

  initial begin
    n_pass      = 0;
    n_total     = 0;
    reset       = 1'b1;
    issue_valid = 1'b0;
    issue_data  = '0;
    out_ready   = 1'b0;
    inj         = 1'b0;
    inj_data    = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_full_wrap();
    test_reset_mid();
    test_err();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/latency_return_buffer.md
# latency_return_buffer

Receive-side companion to the fixed-latency pipeline delay line: it issues credits to the upstream issuer, captures results that emerge from a fixed-latency compute pipe (e.g. a MAC stage chained through a delay line), and presents them downstream with valid/ready backpressure. Credit accounting counts both in-flight and stored results, so a result returning from the non-stallable pipe always finds a free slot. It sits between the compute pipeline output and any backpressuring consumer, such as the activation or writeback stage.

## Interface
- WIDTH, 8, result data width
- LATENCY, 4, issue-to-return delay of the attached pipe in cycles (≥0; informational except under the check macro)
- DEPTH, 8, result storage entries; power of two, ≥2
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- issue_ready  out  1  upstream may issue one operation into the pipe this cycle
- issue_valid  in  1  operation issued into the pipe this cycle; counts only when issue_ready=1
- ret_valid  in  1  result emerging from the pipe this cycle
- ret_data  in  WIDTH  result data
- out_valid  out  1  head result available
- out_ready  in  1  downstream accepts head result
- out_data  out  WIDTH  head result
- credits_used  out  $clog2(DEPTH+1)  in-flight plus stored results
- err  out  1  sticky protocol error (see Configuration)

## Operation
- Issue handshake: issue_fire = issue_valid & issue_ready. Output handshake: out_fire = out_valid & out_ready.
- issue_ready = (credits_used < DEPTH). This is a combinational function of registered credits_used.
- credits_used: +1 on issue_fire only, −1 on out_fire only, unchanged when both or neither occur. Range is 0..DEPTH.
- Storage is a circular buffer with wr_ptr/rd_ptr of $clog2(DEPTH) bits and an occupancy count of $clog2(DEPTH+1) bits. Pointers wrap DEPTH−1→0 naturally.
- ret_valid writes ret_data at wr_ptr unconditionally. The pipe cannot stall, and credit accounting guarantees space.
- out_valid = (occupancy ≠ 0). out_data = mem[rd_ptr]. out_fire advances rd_ptr.
- Simultaneous write and read at equal occupancy: occupancy is unchanged and both pointers advance.
- Full buffer with out_fire and ret_valid in the same cycle is legal: occupancy stays DEPTH.
- ret_valid with occupancy = DEPTH and no out_fire is a protocol violation. The write is dropped, the pointer does not advance, and err sets if checking is compiled in.
- Reset (any time, including mid-operation): pointers, occupancy, credits_used and err clear to 0. The mem contents are not reset. The attached pipe is reset by the same signal, so in-flight results are discarded.

## Timing
- Reset values: issue_ready=1, out_valid=0, out_data=don't-care, credits_used=0, err=0.
- Return-to-output latency is 1 cycle: ret_valid at edge t makes out_valid=1 after edge t and visible in cycle t+1.
- Issue-to-output is LATENCY+1 cycles when downstream is ready.
- Credit release: out_fire at edge t raises issue_ready from cycle t+1 when credits_used was DEPTH.
- Sustained throughput is 1 result/cycle with out_ready held high, provided DEPTH ≥ LATENCY+1. Smaller DEPTH throttles issue.
- out_data stays stable while out_valid=1 and out_ready=0.

## Configuration
- LATENCY_RETURN_BUFFER_CHECK_EN defined:
  - Adds an internal LATENCY-stage shadow of issue_fire.
  - err sets (sticky until reset) when ret_valid ≠ the shadow output in any cycle.
  - err also sets on the overflow write described in Operation.
- Not defined: no shadow logic, and err is tied 0.

## Structure
- Shared package latency_pkg:
  - counter width helper (clog2 of DEPTH+1)
  - default WIDTH/LATENCY/DEPTH constants
- Sub-module ring_buffer holds mem, the pointers, occupancy and wrap logic, with push/pop/full/empty ports.
- The credit counter and checker stay in the top module.

## Test plan
- Reset, then one issue with LATENCY=4: ret_valid at cycle 4 with data 0x5A → out_valid in cycle 5 with out_data=0x5A, credits_used 1→0 on out_fire.
- out_ready=0, issue every cycle, DEPTH=8 → issue_ready drops after 8 issues and credits_used=8. Asserting out_ready for one cycle → issue_ready=1 the next cycle.
- Continuous issue with out_ready=1, DEPTH=8, LATENCY=4 → one result per cycle, in order, with no issue_ready deassertion.
- Full buffer with simultaneous out_fire and ret_valid → occupancy stays 8, ordering preserved across pointer wrap 7→0.
- Assert reset mid-stream with 5 stored and 3 in flight → all outputs return to reset values next cycle. The first post-reset issue returns correct data.
- With the macro defined, inject ret_valid with no matching issue → err=1 and remains 1 until reset. Without the macro → err stays 0.
